// File: rtl/mem_weight_ctrl_pkg.sv
// Shared constants for the weight-memory controller: data/address widths and FSM state codes.
package mem_weight_ctrl_pkg;
  localparam int DWIDTH = 16;
  localparam int WSIZE  = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
endpackage

// File: rtl/mem_weight.sv
// Single-port weight memory with a registered address; read data appears one cycle after its address.
module mem_weight
  import mem_weight_ctrl_pkg::*;
(
  input  logic                     clk,
  input  logic                     we,
  input  logic [WSIZE-1:0]         addr,
  input  logic signed [DWIDTH-1:0] wdata,
  output logic signed [DWIDTH-1:0] rdata
);
  logic signed [DWIDTH-1:0] mem [2**WSIZE];
  logic [WSIZE-1:0]         addr_q;

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    addr_q <= addr;
  end

  // Read through the registered address, so a write is visible on the following read.
  assign rdata = mem[addr_q];
endmodule

// File: rtl/wctrl_burst_gen.sv
// Burst address/count generator: loads base and length, then steps one consecutive address per issue.
module wctrl_burst_gen
  import mem_weight_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             xrst,
  input  logic             load,
  input  logic             step,
  input  logic [WSIZE-1:0] base,
  input  logic [WSIZE:0]   len,
  output logic [WSIZE-1:0] addr,
  output logic             last
);
  logic [WSIZE:0] cnt;

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      addr <= '0;
      cnt  <= '0;
    end else if (load) begin
      addr <= base;
      cnt  <= len;
    end else if (step) begin
      addr <= addr + 1'b1;
      cnt  <= cnt - 1'b1;
    end
  end

  assign last = (cnt == (WSIZE+1)'(1));
endmodule

// File: rtl/mem_weight_ctrl.sv
// Weight-memory sequencer/arbiter: loader writes in IDLE, compute-core burst reads in READ/DRAIN.
// Optional WCTRL_STALL_CNT_EN adds a saturating count of stalled loader cycles.
module mem_weight_ctrl
  import mem_weight_ctrl_pkg::*;
(
  input  logic                     clk,
  input  logic                     xrst,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [WSIZE-1:0]         wr_addr,
  input  logic signed [DWIDTH-1:0] wr_data,
  input  logic                     rd_start,
  input  logic [WSIZE-1:0]         rd_base,
  input  logic [WSIZE:0]           rd_len,
  output logic                     rd_busy,
  output logic                     rd_valid,
  output logic                     rd_last,
  output logic signed [DWIDTH-1:0] rd_data,
  output logic                     mem_we,
  output logic [WSIZE-1:0]         mem_addr,
  output logic signed [DWIDTH-1:0] mem_wdata,
`ifdef WCTRL_STALL_CNT_EN
  output logic [31:0]              stall_cnt,
`endif
  input  logic signed [DWIDTH-1:0] mem_rdata
);
  logic [1:0]       state;
  logic             rdy_q;
  logic             is_idle, issue, last, start_ok;
  logic [WSIZE-1:0] b_addr;

  assign is_idle  = (state == ST_IDLE);
  assign issue    = (state == ST_READ);
  assign start_ok = is_idle & rdy_q & rd_start & (rd_len != '0);

  assign wr_ready  = rdy_q & is_idle;
  assign mem_we    = wr_valid & wr_ready;
  assign mem_wdata = wr_data;
  assign rd_busy   = !is_idle;
  assign rd_data   = mem_rdata;

  // Address is held at zero until the controller comes out of reset.
  always_comb begin
    mem_addr = '0;
    if (rdy_q) mem_addr = is_idle ? wr_addr : b_addr;
  end

  wctrl_burst_gen u_burst (
    .clk  (clk),
    .xrst (xrst),
    .load (start_ok),
    .step (issue),
    .base (rd_base),
    .len  (rd_len),
    .addr (b_addr),
    .last (last)
  );

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      state    <= ST_IDLE;
      rdy_q    <= 1'b0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
    end else begin
      rdy_q    <= 1'b1;
      rd_valid <= issue;
      rd_last  <= issue & last;
      case (state)
        ST_IDLE:  if (start_ok) state <= ST_READ;
        ST_READ:  if (last) state <= ST_DRAIN;
        ST_DRAIN: state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

`ifdef WCTRL_STALL_CNT_EN
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) stall_cnt <= '0;
    else if (rdy_q & wr_valid & !wr_ready & (stall_cnt != 32'hFFFF_FFFF))
      stall_cnt <= stall_cnt + 32'd1;
  end
`endif
endmodule
